// File: rtl/wb_zet_pkg.sv
// wb_zet_pkg: shared types, constants and lane helpers for the ZET external memory bridge.
package wb_zet_pkg;
  typedef enum logic [1:0] {IDLE, REQ, BACKOFF, RESP} bridge_state_t;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  function automatic logic [3:0] lane_sel(input logic hi, input logic [1:0] sel);
    return hi ? {sel, 2'b00} : {2'b00, sel};
  endfunction
  function automatic logic [15:0] lane_rdata(input logic hi, input logic [31:0] dat);
    return hi ? dat[31:16] : dat[15:0];
  endfunction
endpackage

// File: rtl/wb_zet_retry_timer.sv
// wb_zet_retry_timer: slave retry counter plus REQ wait-state timeout.
// The timeout exists only when WB_ZET_EXT_BRIDGE_TIMEOUT_EN is defined.
module wb_zet_retry_timer #(
  parameter int RETRY_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_req,
  input  logic i_ack,
  input  logic i_err,
  input  logic i_rty,
  output logic o_retry_last,
  output logic o_timeout
);
  logic [3:0] r_retry;
  logic       w_rty_win;
  assign w_rty_win = i_req & i_rty & !i_ack & !i_err;
  always_ff @(posedge i_clk) begin
    if (i_rst | i_start) r_retry <= '0;
    else if (w_rty_win) r_retry <= r_retry + 4'd1;
  end
  assign o_retry_last = r_retry == 4'(RETRY_MAX - 1);
`ifdef WB_ZET_EXT_BRIDGE_TIMEOUT_EN
  logic [15:0] r_wait;
  logic        w_wait;
  assign w_wait = i_req & !(i_ack | i_err | i_rty);
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wait <= '0;
    else r_wait <= w_wait ? r_wait + 16'd1 : '0;
  end
  assign o_timeout = w_wait & (r_wait == 16'(TIMEOUT_CYCLES - 1));
`else
  assign o_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: rtl/wb_zet_ext_bridge.sv
// wb_zet_ext_bridge: registered ZET 16-bit Wishbone master to 32-bit external memory slave bridge.
// Optional slave wait-state timeout: define WB_ZET_EXT_BRIDGE_TIMEOUT_EN.
module wb_zet_ext_bridge
  import wb_zet_pkg::*;
#(
  parameter int SLV_ADR_WIDTH  = 32,
  parameter int RETRY_MAX      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [18:0]              wbm_adr_i,
  input  logic [15:0]              wbm_dat_i,
  output logic [15:0]              wbm_dat_o,
  input  logic [1:0]               wbm_sel_i,
  input  logic                     wbm_we_i,
  input  logic                     wbm_tga_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_cyc_i,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [SLV_ADR_WIDTH-1:0] wbs_adr_o,
  output logic [31:0]              wbs_dat_o,
  output logic [3:0]               wbs_sel_o,
  output logic                     wbs_we_o,
  output logic                     wbs_cyc_o,
  output logic                     wbs_stb_o,
  output logic [2:0]               wbs_cti_o,
  output logic [1:0]               wbs_bte_o,
  input  logic                     wbs_ack_i,
  input  logic                     wbs_err_i,
  input  logic                     wbs_rty_i,
  input  logic [31:0]              wbs_dat_i
);
  bridge_state_t            r_state, w_next;
  logic                     r_stb, r_ack, r_err, r_we, r_hi;
  logic [SLV_ADR_WIDTH-1:0] r_adr;
  logic [31:0]              r_dat;
  logic [3:0]               r_sel;
  logic [15:0]              r_rdat;
  logic                     w_req, w_stb, w_ack, w_err, w_load, w_cap;
  logic                     w_retry_last, w_timeout;
  // A request still present in the cycle after our ack/err is the stale one
  assign w_req = wbm_cyc_i & wbm_stb_i & !r_ack & !r_err;
  wb_zet_retry_timer #(
    .RETRY_MAX(RETRY_MAX),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_retry_timer (
    .i_clk(wb_clk_i),
    .i_rst(wb_rst_i),
    .i_start(w_load),
    .i_req(r_state == REQ),
    .i_ack(wbs_ack_i),
    .i_err(wbs_err_i),
    .i_rty(wbs_rty_i),
    .o_retry_last(w_retry_last),
    .o_timeout(w_timeout)
  );
  always_comb begin
    w_next = r_state;
    w_stb  = r_stb;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    w_load = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: if (w_req) begin
        if (wbm_tga_i) w_err = 1'b1;
        else if (wbm_sel_i == 2'b00) w_ack = 1'b1;
        else begin
          w_load = 1'b1;
          w_stb  = 1'b1;
          w_next = REQ;
        end
      end
      REQ: if (wbs_err_i | (w_timeout & !wbs_ack_i & !wbs_rty_i)) begin
        w_stb  = 1'b0;
        w_err  = 1'b1;
        w_next = IDLE;
      end else if (wbs_ack_i) begin
        w_stb  = 1'b0;
        w_cap  = 1'b1;
        w_next = RESP;
      end else if (wbs_rty_i) begin
        w_stb  = 1'b0;
        w_err  = w_retry_last;
        w_next = w_retry_last ? IDLE : BACKOFF;
      end
      BACKOFF: begin
        w_stb  = 1'b1;
        w_next = REQ;
      end
      RESP: begin
        w_ack  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_stb   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_hi    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_next;
      r_stb   <= w_stb;
      r_ack   <= w_ack;
      r_err   <= w_err;
      if (w_load) begin
        r_adr <= SLV_ADR_WIDTH'({wbm_adr_i[18:1], 2'b00});
        r_dat <= {wbm_dat_i, wbm_dat_i};
        r_sel <= lane_sel(wbm_adr_i[0], wbm_sel_i);
        r_we  <= wbm_we_i;
        r_hi  <= wbm_adr_i[0];
      end
      if (w_cap) r_rdat <= lane_rdata(r_hi, wbs_dat_i);
    end
  end
  assign wbm_dat_o = r_rdat;
  assign wbm_ack_o = r_ack;
  assign wbm_err_o = r_err;
  assign wbs_adr_o = r_adr;
  assign wbs_dat_o = r_dat;
  assign wbs_sel_o = r_sel;
  assign wbs_we_o  = r_we;
  assign wbs_cyc_o = r_stb;
  assign wbs_stb_o = r_stb;
  assign wbs_cti_o = WB_CTI_CLASSIC;
  assign wbs_bte_o = WB_BTE_LINEAR;
endmodule

// File: tb/tb_wb_zet_ext_bridge.sv
// tb_wb_zet_ext_bridge: table-driven scoreboard bench for wb_zet_ext_bridge.
module tb_wb_zet_ext_bridge;
  typedef struct {
    logic [19:0] a;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wd;
    logic        tga;
    logic [31:0] sdat;
    int          nrty;
    logic        serr;
    logic [31:0] xadr;
    logic [3:0]  xsel;
    logic [31:0] xwd;
    logic        xerr;
    int          xlat;
    int          xstb;
    logic [15:0] xrd;
  } vec_t;

  logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [18:0] wbm_adr_i = '0;
  logic [15:0] wbm_dat_i = '0, wbm_dat_o;
  logic [1:0]  wbm_sel_i = '0;
  logic        wbm_we_i = 1'b0, wbm_tga_i = 1'b0, wbm_stb_i = 1'b0, wbm_cyc_i = 1'b0;
  logic        wbm_ack_o, wbm_err_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic        wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;

  int   total = 0, bad = 0;
  vec_t vecs[8];
  vec_t exp_q[$];

  wb_zet_ext_bridge #(.SLV_ADR_WIDTH(32), .RETRY_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i), .wbm_tga_i(wbm_tga_i),
    .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_dat_i(wbs_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "/ack"}, 32'(wbm_ack_o), 0);
    chk({n, "/err"}, 32'(wbm_err_o), 0);
    chk({n, "/rdat"}, 32'(wbm_dat_o), 0);
    chk({n, "/cyc"}, 32'(wbs_cyc_o), 0);
    chk({n, "/stb"}, 32'(wbs_stb_o), 0);
    chk({n, "/adr"}, wbs_adr_o, 0);
    chk({n, "/wdat"}, wbs_dat_o, 0);
    chk({n, "/sel"}, 32'(wbs_sel_o), 0);
    chk({n, "/we"}, 32'(wbs_we_o), 0);
  endtask

  task automatic drive_req(input logic [19:0] a, input logic we, input logic [1:0] sel,
                           input logic [15:0] wd, input logic tga);
    wbm_adr_i = a[19:1];
    wbm_we_i  = we;
    wbm_sel_i = sel;
    wbm_dat_i = wd;
    wbm_tga_i = tga;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
  endtask

  task automatic drop_req();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
  endtask

  task automatic run(input vec_t v, input string n);
    int   rty = v.nrty;
    int   stb_n = 0;
    bit   done = 0;
    vec_t e;
    drive_req(v.a, v.we, v.sel, v.wd, v.tga);
    exp_q.push_back(v);
    for (int k = 0; k < 60 && !done; k++) begin
      step();
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;
      if (wbs_stb_o) begin
        stb_n++;
        chk({n, "/adr"}, wbs_adr_o, v.xadr);
        chk({n, "/sel"}, 32'(wbs_sel_o), 32'(v.xsel));
        chk({n, "/wdat"}, wbs_dat_o, v.xwd);
        chk({n, "/we"}, 32'(wbs_we_o), 32'(v.we));
        chk({n, "/cyc"}, 32'(wbs_cyc_o), 1);
        if (v.serr) begin
          wbs_err_i = 1'b1;
          wbs_ack_i = 1'b1;
        end else if (rty > 0) begin
          wbs_rty_i = 1'b1;
          rty--;
        end else begin
          wbs_ack_i = 1'b1;
          wbs_rty_i = v.nrty > 0;
          wbs_dat_i = v.sdat;
        end
      end
      if (wbm_ack_o || wbm_err_o) begin
        done = 1;
        e = exp_q.pop_front();
        chk({n, "/resp"}, {30'd0, wbm_ack_o, wbm_err_o}, {30'd0, !e.xerr, e.xerr});
        chk({n, "/lat"}, k, e.xlat);
        chk({n, "/nstb"}, stb_n, e.xstb);
        chk({n, "/rdat"}, 32'(wbm_dat_o), 32'(e.xrd));
        drop_req();
      end
    end
    if (!done) begin
      chk({n, "/no_response"}, 0, 1);
      void'(exp_q.pop_front());
      drop_req();
    end
    step();
    step();
  endtask

  initial begin
    bit stray;
    vecs[0] = '{a:20'h12345, we:0, sel:2'b11, wd:16'h0000, tga:0, sdat:32'hBEEFCAFE, nrty:0, serr:0,
                xadr:32'h00012344, xsel:4'b0011, xwd:32'h0, xerr:0, xlat:2, xstb:1, xrd:16'hCAFE};
    vecs[1] = '{a:20'h00006, we:1, sel:2'b10, wd:16'hA55A, tga:0, sdat:32'h11112222, nrty:0, serr:0,
                xadr:32'h00000004, xsel:4'b1000, xwd:32'hA55AA55A, xerr:0, xlat:2, xstb:1, xrd:16'h1111};
    vecs[2] = '{a:20'hFFFFE, we:0, sel:2'b11, wd:16'h0000, tga:0, sdat:32'h5A5A1234, nrty:2, serr:0,
                xadr:32'h000FFFFC, xsel:4'b1100, xwd:32'h0, xerr:0, xlat:6, xstb:3, xrd:16'h5A5A};
    vecs[3] = '{a:20'h00100, we:0, sel:2'b11, wd:16'h0000, tga:1, sdat:32'h0, nrty:0, serr:0,
                xadr:32'h0, xsel:4'b0, xwd:32'h0, xerr:1, xlat:0, xstb:0, xrd:16'h5A5A};
    vecs[4] = '{a:20'h00200, we:1, sel:2'b00, wd:16'h7777, tga:0, sdat:32'h0, nrty:0, serr:0,
                xadr:32'h0, xsel:4'b0, xwd:32'h0, xerr:0, xlat:0, xstb:0, xrd:16'h5A5A};
    vecs[5] = '{a:20'h00404, we:0, sel:2'b01, wd:16'h0000, tga:0, sdat:32'hFFFFFFFF, nrty:4, serr:0,
                xadr:32'h00000404, xsel:4'b0001, xwd:32'h0, xerr:1, xlat:7, xstb:4, xrd:16'h5A5A};
    vecs[6] = '{a:20'h00802, we:1, sel:2'b01, wd:16'h1234, tga:0, sdat:32'h0, nrty:0, serr:1,
                xadr:32'h00000800, xsel:4'b0100, xwd:32'h12341234, xerr:1, xlat:1, xstb:1, xrd:16'h5A5A};
    vecs[7] = '{a:20'h7FFFC, we:0, sel:2'b10, wd:16'h0000, tga:0, sdat:32'hDEAD8001, nrty:0, serr:0,
                xadr:32'h0007FFFC, xsel:4'b0010, xwd:32'h0, xerr:0, xlat:2, xstb:1, xrd:16'h8001};

    step();
    step();
    chk_all_zero("reset");
    chk("reset/cti", 32'(wbs_cti_o), 0);
    chk("reset/bte", 32'(wbs_bte_o), 0);
    wb_rst_i = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Stale strobe held one cycle after the zero-select ack must not produce a second ack
    drive_req(20'h00300, 1'b0, 2'b00, 16'h0, 1'b0);
    step();
    chk("stale/ack", 32'(wbm_ack_o), 1);
    step();
    drop_req();
    chk("stale/no_ack", 32'(wbm_ack_o), 0);
    chk("stale/no_err", 32'(wbm_err_o), 0);
    chk("stale/no_cyc", 32'(wbs_cyc_o), 0);
    step();
    step();

    // Silent slave
    drive_req(20'h01000, 1'b0, 2'b11, 16'h0, 1'b0);
`ifdef WB_ZET_EXT_BRIDGE_TIMEOUT_EN
    begin
      int lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
        step();
        if (wbm_err_o) begin
          lat = k;
          chk("timeout/cyc_dropped", 32'(wbs_cyc_o), 0);
          drop_req();
        end
      end
      chk("timeout/lat", lat, 8);
      drop_req();
    end
`else
    for (int k = 0; k < 1000; k++) begin
      step();
      if (k == 0) drop_req();
    end
    chk("hang/cyc", 32'(wbs_cyc_o), 1);
    chk("hang/stb", 32'(wbs_stb_o), 1);
    chk("hang/no_err", 32'(wbm_err_o), 0);
`endif
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    step();

    // Reset in the middle of a slave cycle
    drive_req(20'h00010, 1'b0, 2'b11, 16'h0, 1'b0);
    step();
    drop_req();
    step();
    step();
    chk("midrst/stb_before", 32'(wbs_stb_o), 1);
    wb_rst_i = 1'b1;
    step();
    chk_all_zero("midrst");
    wb_rst_i = 1'b0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      stray |= wbm_ack_o | wbm_err_o | wbs_cyc_o;
    end
    chk("midrst/no_stray", 32'(stray), 0);
    run(vecs[0], "after_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_zet_ext_bridge.md
Name: wb_zet_ext_bridge

Overview:
- Registered Wishbone bridge between the ZET CPU's 16-bit classic master port and the 32-bit external memory slave port.
- Sits directly downstream of the CPU/interconnect memory path and directly upstream of the external RAM controller.
- Performs address translation, byte-lane steering and read-data lane selection.
- Handles slave ack/err/rty; memory cycles only, IO-tagged cycles are rejected.

Parameters:
- SLV_ADR_WIDTH, 32, external address width; bits above 19 are driven to zero.
- RETRY_MAX, 4, number of slave rty responses tolerated before wbm_err_o; range 1..15.
- TIMEOUT_CYCLES, 255, wait-state limit when the timeout feature is compiled in; range 1..65535.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbm_adr_i  in  19  CPU word address [19:1].
- wbm_dat_i  in  16  CPU write data.
- wbm_dat_o  out  16  read data to CPU.
- wbm_sel_i  in  2  CPU byte selects.
- wbm_we_i  in  1  write enable.
- wbm_tga_i  in  1  1 = IO cycle, 0 = memory cycle.
- wbm_stb_i  in  1  strobe.
- wbm_cyc_i  in  1  cycle.
- wbm_ack_o  out  1  one-cycle acknowledge.
- wbm_err_o  out  1  one-cycle error.
- wbs_adr_o  out  SLV_ADR_WIDTH  byte address, word-aligned.
- wbs_dat_o  out  32  write data.
- wbs_sel_o  out  4  byte selects.
- wbs_we_o  out  1  write enable.
- wbs_cyc_o  out  1  cycle.
- wbs_stb_o  out  1  strobe.
- wbs_cti_o  out  3  always 3'b000 (classic).
- wbs_bte_o  out  2  always 2'b00.
- wbs_ack_i  in  1  slave acknowledge.
- wbs_err_i  in  1  slave error.
- wbs_rty_i  in  1  slave retry.
- wbs_dat_i  in  32  slave read data.

Behaviour:
- Clocking and reset: single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: state IDLE; all outputs 0 (wbm_dat_o 16'h0, wbs_* 0, wbm_ack_o/wbm_err_o 0); retry and timeout counters 0.
- Reset asserted mid-transaction drops wbs_cyc_o/wbs_stb_o at the next edge. No ack or err is issued for the abandoned cycle.
- FSM states: IDLE, REQ, BACKOFF, RESP.
- IDLE, request seen (wbm_cyc_i & wbm_stb_i & !wbm_ack_o & !wbm_err_o):
  - If wbm_tga_i = 1: pulse wbm_err_o next cycle; stay in IDLE.
  - Else if wbm_sel_i = 2'b00: pulse wbm_ack_o next cycle with no slave access; wbm_dat_o unchanged.
  - Else: latch address, data, sel and we; go to REQ with wbs_cyc_o = wbs_stb_o = 1 at the same edge.
- Address translation: wbs_adr_o = {zeros, wbm_adr_i[19:2], 2'b00}.
- Write data: wbm_dat_i is replicated on both halves of wbs_dat_o.
- Lane steering by wbm_adr_i[1]:
  - adr[1] = 0: wbs_sel_o = {2'b00, sel}.
  - adr[1] = 1: wbs_sel_o = {sel, 2'b00}.
- REQ: wbs outputs held stable until a response arrives. Priority is err > ack > rty.
  - ack: capture wbs_dat_i[15:0] or [31:16] per latched adr[1] into wbm_dat_o; drop wbs cyc/stb; go to RESP with wbm_ack_o = 1.
  - err: drop wbs cyc/stb; wbm_err_o = 1; go to IDLE.
  - rty: increment retry count.
    - If count reaches RETRY_MAX: err to master.
    - Otherwise: drop wbs stb/cyc for one cycle (BACKOFF), then reissue the same request.
- RESP: wbm_ack_o is high for exactly one cycle, then IDLE.
- Latency: with a slave that acks in the first strobe cycle, wbm_ack_o rises 2 cycles after the request is sampled.
- The CPU drops stb after ack. A still-asserted stb in the cycle after ack/err is ignored (guarded by the !wbm_ack_o & !wbm_err_o term in the IDLE condition).
- Master inputs are ignored outside IDLE.
- wbm_ack_o and wbm_err_o are never asserted together.

Optional Feature:
- Macro: WB_ZET_EXT_BRIDGE_TIMEOUT_EN.
- Defined: a 16-bit counter runs in REQ and clears on any slave response or reissue. When it reaches TIMEOUT_CYCLES, the bridge drops wbs cyc/stb, pulses wbm_err_o and returns to IDLE.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Package wb_zet_pkg:
  - state enum bridge_state_t.
  - constants WB_CTI_CLASSIC = 3'b000 and WB_BTE_LINEAR = 2'b00.
  - functions lane_sel (2 -> 4 bit select) and lane_rdata (32 -> 16 bit read select).
- Sub-module wb_zet_retry_timer: retry counter plus the optional timeout counter with its compare logic.
- The FSM and lane logic stay in the top module.

Test Plan:
- Read, adr 0x12345 word (adr[1] = 0), sel = 11, slave acks first cycle returning 0xBEEF_CAFE -> wbs_adr_o = 0x00012344, wbs_sel_o = 0011, wbm_dat_o = 0xCAFE, ack 2 cycles after the request.
- Write, adr[1] = 1, data 0xA55A, sel = 10 -> wbs_sel_o = 1000, wbs_dat_o = 0xA55AA55A, wbs_we_o = 1, single wbm_ack_o.
- Slave returns rty twice then ack, RETRY_MAX = 4 -> two one-cycle BACKOFF gaps on wbs_stb_o, identical reissued address, one ack.
- IO cycle (tga = 1) -> wbm_err_o pulses once; wbs_cyc_o stays 0. Separately, sel = 00 -> ack with no slave cycle.
- Slave never responds, TIMEOUT_CYCLES = 8, macro defined -> wbm_err_o exactly 8 REQ cycles later, wbs_cyc_o dropped. Without the macro -> still in REQ after 1000 cycles.
- wb_rst_i asserted mid-REQ -> all outputs 0 after one edge, no ack/err. A subsequent read completes normally.
